// File: rtl/execute_mc.sv
// Multicycle execute stage: single-cycle ALU ops plus iterative MUL/DIVU/REMU,
// with valid/ready handshakes on both sides so the pipeline can stall.
module execute_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] imm,
    input  logic             alusrc,
    input  logic [1:0]       aluop,
    input  logic [9:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic             zero,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REMU = 2'd2;

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r, b_r, acc_r, q_r;
    logic [1:0]         iop_r;
    logic [WIDTH-1:0]   aluout_r;
    logic               zero_r;

    logic [WIDTH-1:0]   b_sel_s, alu_s, res_s;
    logic [WIDTH-1:0]   acc_nx_s, a_nx_s, q_nx_s;
    logic [WIDTH:0]     rem_sh_s, diff_s;
    logic [SH_W-1:0]    shamt_s;
    logic               is_iter_s, accept_s;
    logic [1:0]         iop_s;

    assign b_sel_s  = alusrc ? imm : in2;
    assign shamt_s  = b_sel_s[SH_W-1:0];
    assign accept_s = in_valid & in_ready;
    assign aluout   = aluout_r;
    assign zero     = zero_r;

    // Single-cycle ALU result and iterative-op decode
    always_comb begin
        alu_s     = '0;
        is_iter_s = 1'b0;
        iop_s     = OP_MUL;
        case (aluop)
            2'd0: alu_s = in1 + b_sel_s;
            2'd1: alu_s = in1 - b_sel_s;
            default: begin
                case (funct[9:3])
                    7'h00: begin
                        case (funct[2:0])
                            3'd0:    alu_s = in1 + b_sel_s;
                            3'd1:    alu_s = in1 << shamt_s;
                            3'd2:    alu_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(b_sel_s))};
                            3'd3:    alu_s = {{(WIDTH-1){1'b0}}, (in1 < b_sel_s)};
                            3'd4:    alu_s = in1 ^ b_sel_s;
                            3'd5:    alu_s = in1 >> shamt_s;
                            3'd6:    alu_s = in1 | b_sel_s;
                            3'd7:    alu_s = in1 & b_sel_s;
                            default: alu_s = '0;
                        endcase
                    end
                    7'h20: begin
                        case (funct[2:0])
                            3'd0:    alu_s = in1 - b_sel_s;
                            3'd4:    alu_s = ~(in1 | b_sel_s);
                            3'd5:    alu_s = $unsigned($signed(in1) >>> shamt_s);
                            default: alu_s = '0;
                        endcase
                    end
                    7'h01: begin
                        case (funct[2:0])
                            3'd0: begin
                                is_iter_s = 1'b1;
                                iop_s     = OP_MUL;
                            end
                            3'd5: begin
                                is_iter_s = 1'b1;
                                iop_s     = OP_DIVU;
                            end
                            3'd7: begin
                                is_iter_s = 1'b1;
                                iop_s     = OP_REMU;
                            end
                            default: alu_s = '0;
                        endcase
                    end
                    default: alu_s = '0;
                endcase
            end
        endcase
    end

    // One iteration: shift-add multiply or restoring divide (acc_r holds the partial remainder)
    always_comb begin
        acc_nx_s = acc_r;
        a_nx_s   = a_r;
        q_nx_s   = q_r;
        rem_sh_s = {acc_r, q_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, b_r};
        if (iop_r == OP_MUL) begin
            acc_nx_s = q_r[0] ? (acc_r + a_r) : acc_r;
            a_nx_s   = a_r << 1;
            q_nx_s   = q_r >> 1;
        end else if (!diff_s[WIDTH]) begin
            acc_nx_s = diff_s[WIDTH-1:0];
            q_nx_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx_s = rem_sh_s[WIDTH-1:0];
            q_nx_s   = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Final iterative result selection
    always_comb begin
        case (iop_r)
            OP_MUL:  res_s = acc_nx_s;
            OP_DIVU: res_s = q_nx_s;
            OP_REMU: res_s = acc_nx_s;
            default: res_s = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a DONE result can be swapped for a new op in one cycle
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = is_iter_s ? CALC : DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            DONE: begin
                if (out_ready && in_valid) begin
                    state_nx_s = is_iter_s ? CALC : DONE;
                end else if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            IDLE:    in_ready = 1'b1;
            CALC:    busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: operand capture at accept, iteration steps, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            q_r      <= '0;
            iop_r    <= OP_MUL;
            aluout_r <= '0;
            zero_r   <= 1'b1;
        end else if (accept_s) begin
            if (is_iter_s) begin
                cnt_r <= CNT_W'(WIDTH);
                a_r   <= in1;
                b_r   <= b_sel_s;
                acc_r <= '0;
                q_r   <= (iop_s == OP_MUL) ? b_sel_s : in1;
                iop_r <= iop_s;
            end else begin
                aluout_r <= alu_s;
                zero_r   <= (alu_s == '0);
            end
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r - CNT_W'(1);
            acc_r <= acc_nx_s;
            a_r   <= a_nx_s;
            q_r   <= q_nx_s;
            if (cnt_r == CNT_W'(1)) begin
                aluout_r <= res_s;
                zero_r   <= (res_s == '0);
            end
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Scoreboard bench for execute_mc: expected results queued at issue, popped by
// a monitor on every output handshake.
module tb_execute_mc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in1 = '0, in2 = '0, imm = '0;
    logic          alusrc = 1'b0;
    logic [1:0]    aluop = 2'd0;
    logic [9:0]    funct = 10'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  aluout;
    logic          zero;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    execute_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .imm(imm), .alusrc(alusrc), .aluop(aluop),
        .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every consumed result must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %h expected none", aluout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("result", aluout, e);
                chk("zero", 32'(zero), 32'(e == '0));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [9:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] im, input logic src,
                         input logic [W-1:0] e, input bit push,
                         output int acc_cyc, output int waited);
        aluop = op; funct = f; in1 = a; in2 = b; imm = im; alusrc = src;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc_cyc, input bit chk_busy, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            if (chk_busy) begin
                chk("busy_calc", 32'(busy), 32'd1);
                chk("in_ready_calc", 32'(in_ready), 32'd0);
            end
            n++;
            @(negedge clk);
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL out_valid_timeout: got out_valid=0 expected 1");
        end
        lat = cyc - acc_cyc;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [9:0]   f;
        logic [W-1:0] a, b, im;
        logic         src;
        logic [W-1:0] e;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{2'd0, {7'h01, 3'd0}, 32'd5,        32'd7,        32'd0, 1'b0, 32'd12};
        vecs[1]  = '{2'd1, {7'h00, 3'd0}, 32'h1234,     32'h1234,     32'd0, 1'b0, 32'd0};
        vecs[2]  = '{2'd2, {7'h00, 3'd2}, 32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 32'd1};
        vecs[3]  = '{2'd2, {7'h00, 3'd3}, 32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 32'd0};
        vecs[4]  = '{2'd0, {7'h01, 3'd5}, 32'd3,        32'd4,        32'd0, 1'b0, 32'd7};
        vecs[5]  = '{2'd2, {7'h00, 3'd1}, 32'd1,        32'd35,       32'd0, 1'b0, 32'd8};
        vecs[6]  = '{2'd2, {7'h20, 3'd5}, 32'h80000000, 32'hFFFF,     32'd4, 1'b1, 32'hF8000000};
        vecs[7]  = '{2'd2, {7'h20, 3'd4}, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 1'b0, 32'h00000F0F};
        vecs[8]  = '{2'd2, {7'h05, 3'd0}, 32'd9,        32'd9,        32'd0, 1'b0, 32'd0};
        vecs[9]  = '{2'd2, {7'h00, 3'd5}, 32'h80000000, 32'd4,        32'd0, 1'b0, 32'h08000000};
        vecs[10] = '{2'd3, {7'h20, 3'd0}, 32'd3,        32'd5,        32'd0, 1'b0, 32'hFFFFFFFE};
        vecs[11] = '{2'd3, {7'h00, 3'd7}, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 1'b0, 32'h0F000F00};
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ac, wt, lat;

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_aluout", aluout, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // First ADD: latency 1
        issue(vecs[0].op, vecs[0].f, vecs[0].a, vecs[0].b, vecs[0].im, vecs[0].src, vecs[0].e, 1'b1, ac, wt);
        wait_valid(ac, 1'b0, lat);
        chk("add_latency", 32'(lat), 32'd1);
        @(posedge clk);
        #1;

        // Remaining single-cycle vectors back to back
        for (int i = 1; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].src, vecs[i].e, 1'b1, ac, wt);
        end
        repeat (3) @(posedge clk);
        #1;

        // MUL: latency WIDTH+1, busy throughout
        issue(2'd2, {7'h01, 3'd0}, 32'h10001, 32'h10001, 32'd0, 1'b0, 32'h00020001, 1'b1, ac, wt);
        wait_valid(ac, 1'b1, lat);
        chk("mul_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;

        // Divide by zero and normal divides
        issue(2'd2, {7'h01, 3'd5}, 32'd100, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, ac, wt);
        wait_valid(ac, 1'b1, lat);
        chk("divu0_latency", 32'(lat), 32'd33);
        @(posedge clk);
        #1;
        issue(2'd2, {7'h01, 3'd7}, 32'd100, 32'd0, 32'd0, 1'b0, 32'd100, 1'b1, ac, wt);
        wait_valid(ac, 1'b0, lat);
        @(posedge clk);
        #1;
        issue(2'd2, {7'h01, 3'd5}, 32'd100, 32'd7, 32'd0, 1'b0, 32'd14, 1'b1, ac, wt);
        wait_valid(ac, 1'b0, lat);
        @(posedge clk);
        #1;
        issue(2'd2, {7'h01, 3'd7}, 32'd100, 32'd0, 32'd7, 1'b1, 32'd2, 1'b1, ac, wt);
        wait_valid(ac, 1'b0, lat);
        @(posedge clk);
        #1;

        // Backpressure: OR result held, then swapped for XOR without a bubble
        out_ready = 1'b0;
        issue(2'd2, {7'h00, 3'd6}, 32'hF0, 32'h0F, 32'd0, 1'b0, 32'hFF, 1'b1, ac, wt);
        wait_valid(ac, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_aluout", aluout, 32'hFF);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(2'd2, {7'h00, 3'd4}, 32'hFF, 32'h0F, 32'd0, 1'b0, 32'hF0, 1'b1, ac, wt);
        chk("b2b_wait", 32'(wt), 32'd0);
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        chk("b2b_aluout", aluout, 32'hF0);
        repeat (2) @(posedge clk);
        #1;

        // Abort a DIVU mid-flight with reset
        issue(2'd2, {7'h01, 3'd5}, 32'd1000, 32'd3, 32'd0, 1'b0, 32'd0, 1'b0, ac, wt);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_aluout", aluout, 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(2'd0, {7'h00, 3'd0}, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 1'b1, ac, wt);
        wait_valid(ac, 1'b0, lat);
        chk("post_abort_latency", 32'(lat), 32'd1);

        // Quiet period: any stale result would show up as unexpected
        repeat (50) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
